mult_result_buffer: RTL and testbench
=====================================

Name: mult_result_buffer

Overview:
- Sits at the output end of the pipelined multiplier functional unit and presents its results to the common data bus (CDB).
- The multiplier pipeline cannot stall, so completed results (done/tag/product) are captured into a small FIFO and held until the CDB arbiter grants.
- A credit scheme drives can_issue, so the reservation station never issues more multiplies than the buffer can absorb.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- TAG_W, `ROB_TAG_LEN: ROB tag width.
- DATA_W, 64: product width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- mult_start  in  1  pulse; a multiply is issued into the multiplier this cycle.
- mult_done  in  1  multiplier final-stage done.
- mult_tag  in  TAG_W  multiplier output tag; valid when mult_done.
- mult_product  in  DATA_W  multiplier output product; valid when mult_done.
- cdb_grant  in  1  CDB arbiter accepts the head entry this cycle.
- cdb_req  out  1  head entry valid; requesting the CDB.
- cdb_tag  out  TAG_W  head entry tag.
- cdb_value  out  DATA_W  head entry product.
- can_issue  out  1  a new mult_start is permitted this cycle.
- overflow_err  out  1  sticky protocol-violation flag.

Behaviour:
- State: DEPTH-entry circular FIFO of {tag, product}; head/tail pointers; occupancy count (0..DEPTH); in_flight counter (0..DEPTH) of multiplies started but not yet done; overflow_err register.
- Reset (synchronous, active-high): pointers, occupancy, in_flight and overflow_err all go to 0. Outputs read cdb_req=0, cdb_tag=0, cdb_value=0, can_issue=1.
  - Mid-operation reset discards all queued and in-flight results.
  - The multiplier shares the same reset, so its done pipeline clears too and the two stay consistent.
- Push:
  - Taken on a posedge when mult_done=1 and the FIFO is not full.
  - Writes {mult_tag, mult_product} at tail; tail advances mod DEPTH.
  - No bypass: the entry is first visible on cdb_* the cycle after capture (1-cycle latency from mult_done to cdb_req).
- Pop:
  - Taken on a posedge when cdb_req=1 and cdb_grant=1; head advances mod DEPTH.
  - cdb_grant while cdb_req=0 is ignored.
- Outputs:
  - cdb_req = (occupancy != 0).
  - cdb_tag and cdb_value are the head entry, driven combinationally from storage.
  - They must stay stable while cdb_req=1 and no grant arrives.
  - When cdb_req=0, cdb_tag and cdb_value are driven to 0.
- Simultaneous push and pop: both take effect and occupancy is unchanged. This is legal even when full, because the pop frees the slot in the same edge.
- in_flight update:
  - +1 on mult_start, -1 on mult_done.
  - Both in the same cycle leave it unchanged.
  - A mult_done with in_flight=0 and no mult_start in that cycle sets overflow_err; in_flight saturates at 0.
- can_issue = (occupancy + in_flight) < DEPTH, computed combinationally from registered state.
  - It does not credit a same-cycle pop; the check is deliberately conservative.
  - Guarantee: with legal use, every done result finds a free slot.
- Violations:
  - mult_start while can_issue=0 sets overflow_err; the start is still counted (in_flight saturates at DEPTH).
  - mult_done while full with no simultaneous pop drops the result and sets overflow_err.
  - overflow_err clears only on reset.
- Tag values are opaque; there is no reordering, and results leave in multiplier completion order (which equals issue order).

Test Plan:
- Reset then idle:
  - Response: cdb_req=0, can_issue=1, overflow_err=0.
  - Then one start (tag 5, 3x7); the multiplier returns done a fixed latency later.
  - Response: the cycle after done, cdb_req=1, cdb_tag=5, cdb_value=21; with cdb_grant held 1, cdb_req drops next cycle.
- Credit exhaustion, DEPTH=4:
  - Stimulus: starts on 4 consecutive cycles with cdb_grant=0.
  - Response: can_issue=0 after the 4th start; all 4 results are queued in order with tags 1,2,3,4; can_issue returns to 1 one cycle after the first grant pops.
- Full plus simultaneous push/pop:
  - Stimulus: FIFO holds 3 entries, 1 in flight; its done arrives in the same cycle as a grant.
  - Response: occupancy stays 3, head advances, no overflow_err.
- Back-pressure hold:
  - Stimulus: 2 queued results (tag 2, 0xFFFF_FFFF_FFFF_FFFF; tag 3, 0); grant withheld 10 cycles, then granted 2 cycles.
  - Response: cdb_tag/cdb_value stable at tag 2 for 10 cycles, then tag 2 and tag 3 delivered in order.
- Violations:
  - Stimulus: mult_start while can_issue=0.
  - Response: overflow_err=1, which persists until reset.
  - Stimulus: a spurious mult_done with in_flight=0.
  - Response: overflow_err=1 and in_flight stays 0.
- Reset mid-operation:
  - Stimulus: 2 queued, 2 in flight; assert reset for 1 cycle.
  - Response: next cycle cdb_req=0, can_issue=1; no stale results appear later.

Source files
------------

// File: rtl/mult_result_buffer.sv
// Result buffer between the pipelined multiplier and the CDB: a small FIFO of
// {tag, product} plus a credit counter that gates issue so no result is lost.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module mult_result_buffer #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = `ROB_TAG_LEN,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mult_start,
    input  logic              mult_done,
    input  logic [TAG_W-1:0]  mult_tag,
    input  logic [DATA_W-1:0] mult_product,
    input  logic              cdb_grant,
    output logic              cdb_req,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_value,
    output logic              can_issue,
    output logic              overflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]  tag_mem_q  [DEPTH];
    logic [TAG_W-1:0]  tag_mem_d  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  in_flight_q, in_flight_d;
    logic              overflow_q, overflow_d;
    logic              full;
    logic              do_push;
    logic              do_pop;
    logic [CNT_W:0]    credit_sum;

    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        cdb_req    = (count_q != '0);
        do_pop     = cdb_req & cdb_grant;
        do_push    = mult_done & (~full | do_pop);
        // A same-cycle pop is not credited, keeping the issue check conservative.
        credit_sum = {1'b0, count_q} + {1'b0, in_flight_q};
        can_issue  = (credit_sum < (CNT_W + 1)'(DEPTH));
        overflow_err = overflow_q;
        cdb_tag    = cdb_req ? tag_mem_q[head_q]  : '0;
        cdb_value  = cdb_req ? data_mem_q[head_q] : '0;
    end

    always_comb begin
        tag_mem_d  = tag_mem_q;
        data_mem_d = data_mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (do_push) begin
            tag_mem_d[tail_q]  = mult_tag;
            data_mem_d[tail_q] = mult_product;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        in_flight_d = in_flight_q;
        if (mult_start && !mult_done) begin
            if (in_flight_q != CNT_W'(DEPTH)) begin
                in_flight_d = in_flight_q + CNT_W'(1);
            end
        end else if (!mult_start && mult_done) begin
            if (in_flight_q != '0) begin
                in_flight_d = in_flight_q - CNT_W'(1);
            end
        end
        overflow_d = overflow_q
                   | (mult_start & ~can_issue)
                   | (mult_done & ~mult_start & (in_flight_q == '0))
                   | (mult_done & full & ~do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        tag_mem_q  <= tag_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: tb/tb_mult_result_buffer.sv
// Bench for mult_result_buffer: a fixed-latency multiplier model feeds the DUT
// and a queue of expected results is checked whenever the CDB grants.
module tb_mult_result_buffer;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 64;
    localparam int LAT    = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              mult_start = 1'b0;
    logic              mult_done = 1'b0;
    logic [TAG_W-1:0]  mult_tag = '0;
    logic [DATA_W-1:0] mult_product = '0;
    logic              cdb_grant = 1'b0;
    logic              cdb_req;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              can_issue;
    logic              overflow_err;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } result_t;

    result_t expected_q [$];
    logic    pipe_v [LAT];
    result_t pipe_r [LAT];
    int      total = 0;
    int      bad = 0;

    mult_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock(clock),
        .reset(reset),
        .mult_start(mult_start),
        .mult_done(mult_done),
        .mult_tag(mult_tag),
        .mult_product(mult_product),
        .cdb_grant(cdb_grant),
        .cdb_req(cdb_req),
        .cdb_tag(cdb_tag),
        .cdb_value(cdb_value),
        .can_issue(can_issue),
        .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    function automatic logic pipeBusy();
        logic busy = 1'b0;
        for (int i = 0; i < LAT; i++) busy |= pipe_v[i];
        return busy;
    endfunction

    // One clock: drive inputs, score any granted head entry, advance the multiplier model.
    task automatic applyStimulus(input logic start, input logic keep, input logic [TAG_W-1:0] tag,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic grant, input logic spur);
        result_t r;
        result_t e;
        r.tag   = tag;
        r.value = a * b;
        mult_start = start;
        cdb_grant  = grant;
        if (spur) begin
            mult_done    = 1'b1;
            mult_tag     = tag;
            mult_product = r.value;
            expected_q.push_back(r);
        end else begin
            mult_done    = pipe_v[LAT-1];
            mult_tag     = pipe_r[LAT-1].tag;
            mult_product = pipe_r[LAT-1].value;
        end
        if (start && keep) expected_q.push_back(r);
        if (grant && cdb_req) begin
            if (expected_q.size() == 0) begin
                checkOutput("sb_extra", 64'd1, 64'd0);
            end else begin
                e = expected_q.pop_front();
                checkOutput("sb_tag", 64'(cdb_tag), 64'(e.tag));
                checkOutput("sb_value", cdb_value, e.value);
            end
        end
        @(posedge clock);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_r[i] = pipe_r[i-1];
        end
        pipe_v[0] = start;
        pipe_r[0] = r;
        mult_start = 1'b0;
        mult_done  = 1'b0;
        cdb_grant  = 1'b0;
    endtask

    task automatic idle(input logic grant);
        applyStimulus(1'b0, 1'b0, '0, 64'd0, 64'd0, grant, 1'b0);
    endtask

    task automatic startMul(input int tag, input logic [63:0] a, input logic [63:0] b, input logic grant);
        applyStimulus(1'b1, 1'b1, TAG_W'(tag), a, b, grant, 1'b0);
    endtask

    task automatic applyReset();
        reset      = 1'b1;
        mult_start = 1'b0;
        mult_done  = 1'b0;
        cdb_grant  = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_r[i] = '0;
        end
        expected_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic drainAll(input int budget);
        int n = 0;
        while ((expected_q.size() != 0 || pipeBusy() || cdb_req) && n < budget) begin
            idle(1'b1);
            n++;
        end
        if (n >= budget) checkOutput("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        // Reset, then a single 3x7 multiply end to end.
        applyReset();
        checkOutput("rst_req", 64'(cdb_req), 64'd0);
        checkOutput("rst_can_issue", 64'(can_issue), 64'd1);
        checkOutput("rst_err", 64'(overflow_err), 64'd0);
        checkOutput("rst_tag", 64'(cdb_tag), 64'd0);
        checkOutput("rst_value", cdb_value, 64'd0);
        startMul(5, 64'd3, 64'd7, 1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("lat_req_before", 64'(cdb_req), 64'd0);
        idle(1'b0);
        checkOutput("single_req", 64'(cdb_req), 64'd1);
        checkOutput("single_tag", 64'(cdb_tag), 64'd5);
        checkOutput("single_value", cdb_value, 64'd21);
        idle(1'b1);
        checkOutput("single_req_drop", 64'(cdb_req), 64'd0);

        // Credit exhaustion with grant held off.
        applyReset();
        for (int i = 1; i <= 4; i++) begin
            startMul(i, 64'(i), 64'(10 + i), 1'b0);
            checkOutput("credit_issue", 64'(can_issue), (i < 4) ? 64'd1 : 64'd0);
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("credit_full_issue", 64'(can_issue), 64'd0);
        checkOutput("credit_full_req", 64'(cdb_req), 64'd1);
        checkOutput("credit_head_tag", 64'(cdb_tag), 64'd1);
        idle(1'b1);
        checkOutput("credit_return", 64'(can_issue), 64'd1);
        drainAll(20);

        // Three queued, last done lands on the same edge as a grant.
        applyReset();
        for (int i = 1; i <= 4; i++) startMul(i, 64'(100 + i), 64'd3, 1'b0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("pp_pre_issue", 64'(can_issue), 64'd0);
        idle(1'b1);
        checkOutput("pp_head", 64'(cdb_tag), 64'd2);
        checkOutput("pp_issue", 64'(can_issue), 64'd1);
        checkOutput("pp_err", 64'(overflow_err), 64'd0);
        drainAll(20);

        // Head must hold steady under back-pressure.
        applyReset();
        startMul(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        startMul(3, 64'd0, 64'd5, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_tag", 64'(cdb_tag), 64'd2);
            checkOutput("hold_value", cdb_value, 64'hFFFF_FFFF_FFFF_FFFF);
            idle(1'b0);
        end
        idle(1'b1);
        idle(1'b1);
        checkOutput("hold_done_req", 64'(cdb_req), 64'd0);

        // Illegal start, then a spurious done.
        applyReset();
        for (int i = 1; i <= 4; i++) startMul(i, 64'(i), 64'd9, 1'b0);
        applyStimulus(1'b1, 1'b0, TAG_W'(9), 64'd2, 64'd2, 1'b0, 1'b0);
        checkOutput("viol_start_err", 64'(overflow_err), 64'd1);
        for (int i = 0; i < 4; i++) idle(1'b0);
        checkOutput("viol_head_tag", 64'(cdb_tag), 64'd1);
        drainAll(30);
        checkOutput("viol_sticky", 64'(overflow_err), 64'd1);
        applyReset();
        checkOutput("viol_reset_clear", 64'(overflow_err), 64'd0);
        applyStimulus(1'b0, 1'b0, TAG_W'(7), 64'd6, 64'd7, 1'b0, 1'b1);
        checkOutput("spur_err", 64'(overflow_err), 64'd1);
        checkOutput("spur_issue", 64'(can_issue), 64'd1);
        checkOutput("spur_tag", 64'(cdb_tag), 64'd7);
        idle(1'b1);
        checkOutput("spur_issue_after", 64'(can_issue), 64'd1);
        checkOutput("spur_req_after", 64'(cdb_req), 64'd0);

        // Reset with two queued and two in flight.
        applyReset();
        for (int i = 1; i <= 4; i++) startMul(i, 64'(i), 64'd4, 1'b0);
        idle(1'b0);
        checkOutput("mid_pre_req", 64'(cdb_req), 64'd1);
        applyReset();
        checkOutput("mid_req", 64'(cdb_req), 64'd0);
        checkOutput("mid_issue", 64'(can_issue), 64'd1);
        checkOutput("mid_err", 64'(overflow_err), 64'd0);
        for (int i = 0; i < 8; i++) begin
            idle(1'b0);
            checkOutput("mid_no_stale", 64'(cdb_req), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
